// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: window geometry, pixel type, fetch FSM states.
package me_pkg;
    localparam int MACRO_DIM  = 16;
    localparam int SEARCH_DIM = 48;
    localparam int PORT_WIDTH = MACRO_DIM + 1;
    localparam int STRIPES    = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
    localparam int NUM_COLS   = SEARCH_DIM - MACRO_DIM;
    localparam int AW         = $clog2(SEARCH_DIM * STRIPES);
    localparam int RW         = $clog2(SEARCH_DIM);
    localparam int CW         = $clog2(NUM_COLS);
    localparam int MW         = $clog2(PORT_WIDTH);

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_ACK,
        DONE
    } sw_fetch_state_t;
endpackage

// File: rtl/sw_rotator.sv
// Combinational PORT_WIDTH-way rotate: lane l takes input lane (l + amt) mod PORT_WIDTH.
module sw_rotator
    import me_pkg::*;
(
    input  logic [PORT_WIDTH-1:0][7:0] pix,
    input  logic [MW-1:0]              amt,
    output logic [PORT_WIDTH-1:0][7:0] rot
);
    localparam logic [MW:0] PW_WIDE = (MW+1)'(PORT_WIDTH);

    generate
        for (genvar gi = 0; gi < PORT_WIDTH; gi++) begin : g_lane
            logic [MW:0]   sum;
            logic [MW-1:0] src;
            pixel_t        lane;

            assign sum  = (MW+1)'(gi) + (MW+1)'(amt);
            // amt < PORT_WIDTH, so one conditional subtract is a full modulo
            assign src  = MW'((sum >= PW_WIDE) ? sum - PW_WIDE : sum);
            assign lane = pix[src];
            assign rot[gi] = lane;
        end
    endgenerate
endmodule

// File: rtl/sw_fetch_ctrl.sv
// Search-window fetch controller: scans column offsets over the banked window RAM.
// Define SW_FETCH_ROTATE_EN to rotate pix_out into window column order here.
module sw_fetch_ctrl
    import me_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          ready,
    input  logic                          col_ack,
    output logic [PORT_WIDTH-1:0][AW-1:0] bank_addr,
    input  logic [PORT_WIDTH-1:0][7:0]    bank_rdata,
    output logic [PORT_WIDTH-1:0][7:0]    pix_out,
    output logic                          pix_valid,
    output logic [RW-1:0]                 row_idx,
    output logic [CW-1:0]                 col_idx,
    output logic [MW-1:0]                 amt,
    output logic                          col_done,
    output logic                          done
);
    localparam logic [AW-1:0] SD_ADDR  = AW'(SEARCH_DIM);
    localparam logic [RW-1:0] LAST_ROW = RW'(SEARCH_DIM - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);
    localparam logic [MW-1:0] LAST_AMT = MW'(PORT_WIDTH - 1);

    sw_fetch_state_t state_reg;
    logic [RW-1:0]   row_reg;
    logic [CW-1:0]   col_reg;
    logic [MW-1:0]   amt_i_reg;
    logic [MW-1:0]   amt_step;
    logic [AW-1:0]   base_reg;
    logic [AW-1:0]   base_step;

    logic [PORT_WIDTH-1:0][AW-1:0] addr_row_next;
    logic [PORT_WIDTH-1:0][AW-1:0] addr_col_next;
    logic [PORT_WIDTH-1:0][AW-1:0] bank_addr_reg;
    logic [PORT_WIDTH-1:0][7:0]    lane_data;

    logic          ready_reg;
    logic          pix_valid_reg;
    logic [RW-1:0] row_idx_reg;
    logic [CW-1:0] col_idx_reg;
    logic [MW-1:0] amt_reg;
    logic          col_done_reg;
    logic          done_reg;

    // base_reg is stripe * SEARCH_DIM; it advances when the rotation wraps
    assign amt_step  = (amt_i_reg == LAST_AMT) ? '0 : amt_i_reg + MW'(1);
    assign base_step = (amt_i_reg == LAST_AMT) ? base_reg + SD_ADDR : base_reg;

    generate
        for (genvar gi = 0; gi < PORT_WIDTH; gi++) begin : g_bank
            assign addr_row_next[gi] = base_reg + ((MW'(gi) < amt_i_reg) ? SD_ADDR : '0)
                                       + AW'(row_reg) + AW'(1);
            assign addr_col_next[gi] = base_step + ((MW'(gi) < amt_step) ? SD_ADDR : '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            amt_i_reg     <= '0;
            base_reg      <= '0;
            bank_addr_reg <= '0;
            ready_reg     <= 1'b1;
            pix_valid_reg <= 1'b0;
            row_idx_reg   <= '0;
            col_idx_reg   <= '0;
            amt_reg       <= '0;
            col_done_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            pix_valid_reg <= 1'b0;
            col_done_reg  <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= SCAN;
                        ready_reg     <= 1'b0;
                        row_reg       <= '0;
                        col_reg       <= '0;
                        amt_i_reg     <= '0;
                        base_reg      <= '0;
                        bank_addr_reg <= '0;
                    end
                end
                SCAN: begin
                    // bank_addr already carries this row; tag the beat that returns next cycle
                    pix_valid_reg <= 1'b1;
                    row_idx_reg   <= row_reg;
                    col_idx_reg   <= col_reg;
                    amt_reg       <= amt_i_reg;
                    col_done_reg  <= (row_reg == LAST_ROW);
                    if (row_reg == LAST_ROW) begin
                        state_reg <= WAIT_ACK;
                    end else begin
                        row_reg       <= row_reg + RW'(1);
                        bank_addr_reg <= addr_row_next;
                    end
                end
                WAIT_ACK: begin
                    if (col_ack) begin
                        if (col_reg == LAST_COL) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= SCAN;
                            row_reg       <= '0;
                            col_reg       <= col_reg + CW'(1);
                            amt_i_reg     <= amt_step;
                            base_reg      <= base_step;
                            bank_addr_reg <= addr_col_next;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

`ifdef SW_FETCH_ROTATE_EN
    sw_rotator u_rotator (
        .pix (bank_rdata),
        .amt (amt_reg),
        .rot (lane_data)
    );
`else
    assign lane_data = bank_rdata;
`endif

    // Bank data arrives one cycle after its address, aligned with the registered tags
    assign pix_out   = pix_valid_reg ? lane_data : '0;
    assign bank_addr = bank_addr_reg;
    assign ready     = ready_reg;
    assign pix_valid = pix_valid_reg;
    assign row_idx   = row_idx_reg;
    assign col_idx   = col_idx_reg;
    assign amt       = amt_reg;
    assign col_done  = col_done_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_sw_fetch_ctrl.sv
// Bench for sw_fetch_ctrl: random ack/start stimulus against a cycle-level window-scan model.
`timescale 1ns/1ps
module tb_sw_fetch_ctrl;
    import me_pkg::*;

    localparam int PW = PORT_WIDTH;
    localparam int SD = SEARCH_DIM;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic col_ack = 1'b0;
    logic ready, pix_valid, col_done, done;
    logic [PW-1:0][AW-1:0] bank_addr;
    logic [PW-1:0][AW-1:0] prev_addr;
    logic [PW-1:0][7:0]    bank_rdata = '0;
    logic [PW-1:0][7:0]    pix_out;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic [MW-1:0] amt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] pic [SD][SD];
    logic [7:0] mem [PW][SD*STRIPES];

    // model state
    bit m_busy = 0;
    int m_col = 0;
    int m_col_start = -1000;
    int m_done_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int b = 0; b < PW; b++)
            bank_rdata[b] <= (int'(bank_addr[b]) < SD*STRIPES) ? mem[b][bank_addr[b]] : 8'h00;
    end

    sw_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .col_ack    (col_ack),
        .bank_addr  (bank_addr),
        .bank_rdata (bank_rdata),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .amt        (amt),
        .col_done   (col_done),
        .done       (done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window column that lane l must carry for offset o
    function automatic int lane_col(input int o, input int l);
`ifdef SW_FETCH_ROTATE_EN
        return o + l;
`else
        return o + ((l - (o % PW) + PW) % PW);
`endif
    endfunction

    function automatic int exp_addr(input int o, input int b, input int r);
        return ((o / PW) + ((b < (o % PW)) ? 1 : 0)) * SD + r;
    endfunction

`ifdef SW_FETCH_ROTATE_EN
    localparam int LANE_C20 = 0;
    localparam int LANE_C47 = 16;
`else
    localparam int LANE_C20 = 3;
    localparam int LANE_C47 = 13;
`endif

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"}, ready, 1);
        chk({tag, " pix_valid"}, pix_valid, 0);
        chk({tag, " col_done"}, col_done, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " row_idx"}, row_idx, 0);
        chk({tag, " col_idx"}, col_idx, 0);
        chk({tag, " amt"}, amt, 0);
        chk({tag, " pix_out_zero"}, (pix_out == '0) ? 1 : 0, 1);
        chk({tag, " bank_addr_zero"}, (bank_addr == '0) ? 1 : 0, 1);
    endtask

    // Compare process: outputs of cycle cyc against the model, then advance the model
    initial begin
        int r, k, o;
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_col = 0; m_col_start = -1000; m_done_cyc = -1;
                chk_reset_outputs("in_reset");
            end
            exp_valid = m_busy && (cyc >= m_col_start) && (cyc <= m_col_start + SD - 1);
            r = cyc - m_col_start;
            o = m_col;
            chk("ready", ready, m_busy ? 0 : 1);
            chk("pix_valid", pix_valid, exp_valid ? 1 : 0);
            chk("done", done, (cyc == m_done_cyc) ? 1 : 0);
            chk("col_done", col_done, (exp_valid && r == SD - 1) ? 1 : 0);
            if (exp_valid && pix_valid) begin
                chk("row_idx", row_idx, r);
                chk("col_idx", col_idx, o);
                chk("amt", amt, o % PW);
                k = 0;
                for (int l = PW - 1; l >= 0; l--)
                    if (pix_out[l] !== pic[r][lane_col(o, l)]) k = l;
                chk("pix_out_lane", pix_out[k], pic[r][lane_col(o, k)]);
                k = 0;
                for (int b = PW - 1; b >= 0; b--)
                    if (int'(prev_addr[b]) != exp_addr(o, b, r)) k = b;
                chk("bank_addr", prev_addr[k], exp_addr(o, k, r));
                if (o == 0 && r == 5) begin
                    chk("o0r5 addr bank0", prev_addr[0], 5);
                    chk("o0r5 addr bank16", prev_addr[16], 5);
                end
                if (o == 20 && r == 7) begin
                    chk("o20r7 addr bank2", prev_addr[2], 103);
                    chk("o20r7 addr bank3", prev_addr[3], 55);
                    chk("o20r7 column20", pix_out[LANE_C20], pic[7][20]);
                end
                if (o == 31 && r == 10) begin
                    chk("o31r10 addr bank13", prev_addr[13], 106);
                    chk("o31r10 addr bank14", prev_addr[14], 58);
                    chk("o31r10 column47", pix_out[LANE_C47], pic[10][47]);
                end
                if (r == SD - 1) $display("column %0d complete at cycle %0d", o, cyc);
            end
            prev_addr = bank_addr;
            if (rst_n) begin
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1; m_col = 0; m_col_start = cyc + 2; m_done_cyc = -1;
                    end
                end else if (cyc == m_done_cyc) begin
                    m_busy = 0;
                end else if (m_done_cyc < 0 && col_ack && cyc >= m_col_start + SD - 1) begin
                    if (m_col == NUM_COLS - 1) begin
                        m_done_cyc = cyc + 1; m_col_start = -1000;
                    end else begin
                        m_col++; m_col_start = cyc + 2;
                    end
                end
            end
        end
    end

    task automatic run_scan(input bit rnd, input int rst_col, input int rst_row,
                            output int start_cyc, output int done_cyc);
        int wait_left, guard;
        bit fin;
        wait_left = -1; guard = 0; fin = 0; done_cyc = -1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin) begin
            if (done) begin
                start = 1'b0; col_ack = 1'b0;
                done_cyc = cyc; fin = 1;
            end else if (rst_col >= 0 && pix_valid && int'(col_idx) == rst_col
                         && int'(row_idx) == rst_row) begin
                start = 1'b0; col_ack = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs("mid_scan_reset");
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                fin = 1;
            end else if (guard > 4000) begin
                checks++; failures++;
                $display("FAIL scan_timeout: got no done after %0d cycles, required done", guard);
                start = 1'b0; col_ack = 1'b0;
                fin = 1;
            end else begin
                if (pix_valid && col_done)
                    wait_left = rnd ? ((int'(col_idx) == 5) ? 10 : $urandom_range(0, 3)) : 0;
                if (!rnd) begin
                    col_ack = 1'b1;
                end else if (wait_left == 0) begin
                    col_ack = 1'b1;
                    wait_left = -1;
                end else begin
                    col_ack = (wait_left < 0) && ($urandom_range(0, 9) == 0);
                    if (pix_valid && int'(row_idx) == SD - 2) col_ack = 1'b1;
                    if (wait_left > 0) wait_left--;
                end
                start = rnd && ($urandom_range(0, 19) == 0);
                @(posedge clk); #1;
                guard++;
            end
        end
    endtask

    initial begin
        int s_cyc, d_cyc;
        for (int r = 0; r < SD; r++)
            for (int c = 0; c < SD; c++)
                pic[r][c] = 8'($urandom);
        for (int b = 0; b < PW; b++)
            for (int st = 0; st < STRIPES; st++)
                for (int r = 0; r < SD; r++)
                    mem[b][st*SD + r] = (st*PW + b < SD) ? pic[r][st*PW + b] : 8'hEE;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // zero-latency acks: inclusive start-to-done span is NUM_COLS*(SEARCH_DIM+1)+2
        run_scan(1'b0, -1, -1, s_cyc, d_cyc);
        chk("scan_length", d_cyc - s_cyc + 1, 1570);
        repeat (3) @(posedge clk);
        #1;
        run_scan(1'b1, -1, -1, s_cyc, d_cyc);
        repeat (2) @(posedge clk);
        #1;
        run_scan(1'b1, 12, 30, s_cyc, d_cyc);
        repeat (2) @(posedge clk);
        #1;
        run_scan(1'b0, -1, -1, s_cyc, d_cyc);
        chk("restart_scan_length", d_cyc - s_cyc + 1, 1570);
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sw_fetch_ctrl.md
# sw_fetch_ctrl

Search-window fetch controller for the inter-prediction motion-estimation path. It owns the scan sequence over the banked search-window RAM (PORT_WIDTH = MACRO_DIM+1 single-port banks, column-striped). Per cycle it generates per-bank read addresses with stripe translation and rotates the returned bank data into window column order. It sits between the search-window BRAM banks and the `me` SAD core, pacing the core one candidate column at a time via a per-column acknowledge.

## Interface
- MACRO_DIM, 16, macroblock edge in pixels
- SEARCH_DIM, 48, search-window edge in pixels
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin a full window scan (honoured only in IDLE)
- ready  out  1  high in IDLE only
- col_ack  in  1  core has finished consuming the current column; honoured only in WAIT_ACK
- bank_addr  out  PORT_WIDTH x AW  per-bank read address; AW = clog2(SEARCH_DIM*STRIPES), STRIPES = ceil(SEARCH_DIM/PORT_WIDTH)
- bank_rdata  in  PORT_WIDTH x 8  bank read data, 1-cycle synchronous read latency
- pix_out  out  PORT_WIDTH x 8  window-ordered pixels for one search row
- pix_valid  out  1  pix_out, row_idx, col_idx valid
- row_idx  out  clog2(SEARCH_DIM)  search row of pix_out
- col_idx  out  clog2(NUM_COLS)  column offset of pix_out; NUM_COLS = SEARCH_DIM-MACRO_DIM
- amt  out  clog2(PORT_WIDTH)  rotation amount aligned with pix_out
- col_done  out  1  pulse with the last row beat of each column
- done  out  1  single-cycle pulse after final col_ack

## Operation
- Column offset o (0..NUM_COLS-1) is tracked as stripe s = o/PORT_WIDTH and issue-side rotation amt_i = o%PORT_WIDTH. These are incremental counters: amt_i wraps PORT_WIDTH-1→0 with s+1. No divider is used.
- Bank b address for row r: ((s + (b < amt_i ? 1 : 0)) * SEARCH_DIM) + r. Computed as base + r, with base = s*SEARCH_DIM maintained by adding SEARCH_DIM on stripe step.
- Rotation: pix_out[l] = bank_rdata[(l + amt) % PORT_WIDTH]. Uses amt registered from the issue cycle.
- FSM states:
  - IDLE: start → SCAN. Row, offset, stripe and base are cleared.
  - SCAN: one row issued per cycle. At r = SEARCH_DIM-1 → WAIT_ACK.
  - WAIT_ACK: col_ack with o = NUM_COLS-1 → DONE. col_ack otherwise → SCAN with o+1 and r = 0.
  - DONE: one cycle, then → IDLE.
- Ignored inputs: start outside IDLE; col_ack outside WAIT_ACK.
- col_ack and the last-row issue can coincide. The ack is then ignored, because the state is still SCAN. The core must hold col_ack until it sees ready-for-next-column (WAIT_ACK is entered the cycle after).
- bank_addr holds its last value outside SCAN.
- Reset mid-scan: immediate return to IDLE. All counters and outputs are cleared; no done pulse.

## Timing
- Reset values: ready=1; pix_valid, col_done, done, row_idx, col_idx, amt = 0; pix_out = 0; bank_addr = 0.
- Address issued in cycle t → pix_out/pix_valid/row_idx/col_idx/amt in cycle t+1. bank_addr is registered from counters, so the first address appears the cycle after the start pulse.
- Per column: SEARCH_DIM valid beats back to back. col_done is coincident with row_idx = SEARCH_DIM-1.
- First address after col_ack: the cycle after col_ack is sampled.
- done asserts the cycle after the final col_ack. ready returns high the cycle after done.
- Minimum scan length with zero-latency acks: NUM_COLS*(SEARCH_DIM+1)+2 cycles. This is 1570 cycles for the defaults.

## Configuration
- SW_FETCH_ROTATE_EN defined: the rotator is instantiated and pix_out is in window column order.
- SW_FETCH_ROTATE_EN undefined: pix_out = bank_rdata, registered through the same 1-cycle alignment with no rotation. The `me` core consumes amt to rotate internally. All other timing is identical.

## Structure
- Shared package me_pkg holds:
  - PORT_WIDTH, STRIPES, NUM_COLS and AW as functions of MACRO_DIM/SEARCH_DIM;
  - the pixel_t (8-bit) typedef;
  - the sw_fetch_state_t enum {IDLE, SCAN, WAIT_ACK, DONE}.
- One sub-module, sw_rotator: a combinational PORT_WIDTH-way barrel rotate by amt. It is instantiated only under SW_FETCH_ROTATE_EN.

## Test plan
- Reset, then start with col_ack tied high → 32 columns × 48 beats. done occurs 1570 cycles after start; row_idx cycles 0..47 per column.
- Offset 0, row 5 → all bank_addr = 5; pix_out[l] = column l, row 5.
- Offset 20 (s=1, amt=3), row 7 → banks 0–2 addr 103, banks 3–16 addr 55; pix_out[0] = window column 20. Data checked against a reference model of the search picture.
- Offset 31 (s=1, amt=14) → banks 0–13 addr 96+r, banks 14–16 addr 48+r; pix_out[16] = column 47.
- col_ack withheld 10 cycles in WAIT_ACK → no pix_valid during the wait. Also: start pulsed mid-scan and col_ack pulsed during SCAN are both ignored, and the sequence is unchanged.
- rst_n asserted at offset 12, row 30 → outputs return to reset values in the same cycle. A fresh start restarts from offset 0, row 0.
